count_ctrl: RTL

Run controller for the 8-bit synchronous counter. It sequences load, run, pause, and terminal stop from user commands. It replaces the derived slow clock with a single-cycle count-enable strobe generated in the system clock domain. It sits between the board switches/buttons and the counter, and drives the counter's load and enable inputs.

---
 rtl/count_ctrl_if.sv | 25 ++
 rtl/count_ctrl.sv | 97 +++++++++
 2 files changed

// File: rtl/count_ctrl_if.sv
// Command/status bundle between the board controls, count_ctrl and the 8-bit counter.
// master: the run controller; slave: the side driving commands and observing strobes.
interface count_ctrl_if;
    logic       start;
    logic       stop;
    logic       clear;
    logic [7:0] start_val;
    logic [7:0] end_val;
    logic [7:0] cnt_val;
    logic       cnt_ld;
    logic [7:0] cnt_ld_val;
    logic       cnt_en;
    logic       busy;
    logic       done;

    modport master (
        input  start, stop, clear, start_val, end_val, cnt_val,
        output cnt_ld, cnt_ld_val, cnt_en, busy, done
    );

    modport slave (
        output start, stop, clear, start_val, end_val, cnt_val,
        input  cnt_ld, cnt_ld_val, cnt_en, busy, done
    );
endinterface

// File: rtl/count_ctrl.sv
// Run controller for the 8-bit counter: load/run/pause/done sequencing with a DIV-cycle enable strobe.
// Optional COUNT_CTRL_AUTORELOAD_EN: DONE lasts one cycle and restarts the run automatically.
module count_ctrl #(
    parameter int unsigned DIV = 100_000_000
) (
    input  logic         clk,
    input  logic         rst,
    count_ctrl_if.master bus
);
    localparam int unsigned DW       = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] div_q, div_nxt;
    logic          ld_nxt;
    logic          en_nxt;
    logic [7:0]    ld_val_nxt;
    logic          start_ok;

    // stop outranks start in every state
    assign start_ok = bus.start & ~bus.stop;

    // Next state, divider and strobe values; clear overrides everything
    always_comb begin
        state_nxt  = state;
        div_nxt    = div_q;
        ld_nxt     = 1'b0;
        en_nxt     = 1'b0;
        ld_val_nxt = bus.cnt_ld_val;
        if (bus.clear) begin
            state_nxt  = S_IDLE;
            div_nxt    = '0;
            ld_nxt     = 1'b1;
            ld_val_nxt = 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) state_nxt = S_LOAD;
                end
                S_LOAD: begin
                    state_nxt = S_RUN;
                    div_nxt   = '0;
                end
                S_RUN: begin
                    // a stop cycle does not advance the divider, so a tick it coincides with is deferred
                    if (bus.stop) begin
                        state_nxt = S_PAUSE;
                    end else if (div_q == DIV_LAST) begin
                        div_nxt = '0;
                        if (bus.cnt_val == bus.end_val) state_nxt = S_DONE;
                        else                            en_nxt    = 1'b1;
                    end else begin
                        div_nxt = div_q + DW'(1);
                    end
                end
                S_PAUSE: begin
                    if (start_ok) state_nxt = S_RUN;
                end
                S_DONE: begin
`ifdef COUNT_CTRL_AUTORELOAD_EN
                    if (!bus.stop) state_nxt = S_LOAD;
`else
                    if (start_ok) state_nxt = S_LOAD;
`endif
                end
                default: state_nxt = S_IDLE;
            endcase
            if (state_nxt == S_LOAD) begin
                ld_nxt     = 1'b1;
                ld_val_nxt = bus.start_val;
            end
        end
    end

    // State, divider and all outputs registered together (Moore outputs)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            div_q          <= '0;
            bus.cnt_ld     <= 1'b0;
            bus.cnt_ld_val <= 8'h00;
            bus.cnt_en     <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            state          <= state_nxt;
            div_q          <= div_nxt;
            bus.cnt_ld     <= ld_nxt;
            bus.cnt_ld_val <= ld_val_nxt;
            bus.cnt_en     <= en_nxt;
            bus.busy       <= (state_nxt == S_LOAD) || (state_nxt == S_RUN) || (state_nxt == S_PAUSE);
            bus.done       <= (state_nxt == S_DONE);
        end
    end
endmodule
